// File: rtl/seq_det_pkg.sv
// Shared encodings for the sequence-detector scheduler slice.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_INC    = 2'd0;
    localparam logic [1:0] MODE_DEC    = 2'd1;
    localparam logic [1:0] MODE_STEADY = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    localparam int DEF_DW = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set request at or above ptr,
// wrapping around.
module rr_pick
    import seq_det_pkg::*;
#(
    parameter int N = 2,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);

    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any    = 1'b1;
                winner = W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-shares one sequence detector among N_REQ stream sources,
// flushing detector history before every granted burst.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 16
) (
    input  logic                SYSCLK,
    input  logic                RST_B,
    input  logic [N_REQ-1:0]    REQ,
    input  logic [N_REQ-1:0]    REQ_VALID,
    input  logic [N_REQ-1:0]    REQ_LAST,
    input  logic [2*N_REQ-1:0]  REQ_MODE,
    input  logic [DW*N_REQ-1:0] REQ_DATA,
    output logic [N_REQ-1:0]    GNT,
    output logic [N_REQ-1:0]    RSP_VALID,
    output logic [DW-1:0]       RSP_DATA,
    output logic                BUSY,
    output logic                DET_RST_B,
    output logic                DET_IN_VALID,
    output logic [1:0]          DET_MODE,
    output logic [DW-1:0]       DET_DATA_IN,
    input  logic                DET_OUT_VALID,
    input  logic [DW-1:0]       DET_DATA_OUT
);

    localparam int OW = idx_w(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    state_t         state;
    logic [OW-1:0]  owner;
    logic [OW-1:0]  ptr;
    logic [OW-1:0]  pick;
    logic [OW-1:0]  owner_inc;
    logic           any_req;
    logic [CW-1:0]  cnt;
    logic           active;
    logic           own_req;
    logic           beat;
    logic           burst_end;
    logic [N_REQ-1:0] owner_oh;

    rr_pick #(
        .N (N_REQ),
        .W (OW)
    ) u_rr_pick (
        .req    (REQ),
        .ptr    (ptr),
        .winner (pick),
        .any    (any_req)
    );

    assign active    = (state == ST_ACTIVE);
    assign own_req   = REQ[owner];
    assign beat      = REQ_VALID[owner];
    assign owner_oh  = N_REQ'(1) << owner;
    assign owner_inc = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

    // Ending beat is still forwarded; any end condition closes the burst.
    assign burst_end = !own_req
                     || (beat && REQ_LAST[owner])
                     || (beat && cnt == CNT_LAST);

    assign GNT          = active ? owner_oh : '0;
    assign DET_IN_VALID = active && beat;
    assign DET_MODE     = active ? REQ_MODE[2*int'(owner) +: 2] : MODE_HOLD;
    assign DET_DATA_IN  = active ? REQ_DATA[DW*int'(owner) +: DW] : '0;
    assign RSP_VALID    = (active && DET_OUT_VALID) ? owner_oh : '0;
    assign RSP_DATA     = active ? DET_DATA_OUT : '0;
    assign BUSY         = (state != ST_IDLE);

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            state     <= ST_IDLE;
            owner     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            DET_RST_B <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner     <= pick;
                        state     <= ST_FLUSH;
                        DET_RST_B <= 1'b0;
                    end else begin
                        DET_RST_B <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    cnt       <= '0;
                    DET_RST_B <= 1'b1;
                    state     <= own_req ? ST_ACTIVE : ST_IDLE;
                end
                ST_ACTIVE: begin
                    DET_RST_B <= 1'b1;
                    if (beat && cnt != CNT_MAX)
                        cnt <= cnt + 1'b1;
                    if (burst_end) begin
                        state <= ST_IDLE;
                        ptr   <= owner_inc;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    DET_RST_B <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler with a small detector model.
module tb_seq_det_scheduler;
    import seq_det_pkg::*;

    logic       SYSCLK;
    logic       RST_B;
    logic [1:0] REQ;
    logic [1:0] REQ_VALID;
    logic [1:0] REQ_LAST;
    logic [3:0] REQ_MODE;
    logic [7:0] REQ_DATA;
    logic [1:0] GNT;
    logic [1:0] RSP_VALID;
    logic [3:0] RSP_DATA;
    logic       BUSY;
    logic       DET_RST_B;
    logic       DET_IN_VALID;
    logic [1:0] DET_MODE;
    logic [3:0] DET_DATA_IN;
    logic       DET_OUT_VALID;
    logic [3:0] DET_DATA_OUT;

    int n_cmp;
    int n_err;

    seq_det_scheduler #(
        .N_REQ     (2),
        .DW        (4),
        .MAX_BURST (16)
    ) dut (
        .SYSCLK        (SYSCLK),
        .RST_B         (RST_B),
        .REQ           (REQ),
        .REQ_VALID     (REQ_VALID),
        .REQ_LAST      (REQ_LAST),
        .REQ_MODE      (REQ_MODE),
        .REQ_DATA      (REQ_DATA),
        .GNT           (GNT),
        .RSP_VALID     (RSP_VALID),
        .RSP_DATA      (RSP_DATA),
        .BUSY          (BUSY),
        .DET_RST_B     (DET_RST_B),
        .DET_IN_VALID  (DET_IN_VALID),
        .DET_MODE      (DET_MODE),
        .DET_DATA_IN   (DET_DATA_IN),
        .DET_OUT_VALID (DET_OUT_VALID),
        .DET_DATA_OUT  (DET_DATA_OUT)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    // Detector model: hit once three consecutive beats follow the mode rule.
    logic       det_rstn;
    logic       have_prev;
    logic [3:0] prev;
    logic [1:0] run;
    logic       rel_ok;
    logic [1:0] run_nxt;
    logic       upd;

    assign det_rstn = DET_RST_B & RST_B;
    assign upd      = DET_IN_VALID && (DET_MODE != MODE_HOLD);

    always_comb begin
        rel_ok = 1'b0;
        case (DET_MODE)
            MODE_INC:    rel_ok = (DET_DATA_IN == prev + 4'd1);
            MODE_DEC:    rel_ok = (DET_DATA_IN == prev - 4'd1);
            MODE_STEADY: rel_ok = (DET_DATA_IN == prev);
            default:     rel_ok = 1'b0;
        endcase
        run_nxt = 2'd1;
        if (have_prev && rel_ok)
            run_nxt = (run == 2'd3) ? 2'd3 : run + 2'd1;
        DET_OUT_VALID = upd && (run_nxt == 2'd3);
        DET_DATA_OUT  = DET_OUT_VALID ? DET_DATA_IN : 4'd0;
    end

    always_ff @(posedge SYSCLK or negedge det_rstn) begin
        if (!det_rstn) begin
            have_prev <= 1'b0;
            prev      <= 4'd0;
            run       <= 2'd0;
        end else if (upd) begin
            have_prev <= 1'b1;
            prev      <= DET_DATA_IN;
            run       <= run_nxt;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic beat(input int i, input logic v, input logic l,
                        input logic [1:0] m, input logic [3:0] d);
        REQ_VALID[i]        = v;
        REQ_LAST[i]         = l;
        REQ_MODE[2*i +: 2]  = m;
        REQ_DATA[4*i +: 4]  = d;
    endtask

    task automatic quiet();
        REQ_VALID = '0;
        REQ_LAST  = '0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        RST_B     = 1'b0;
        REQ       = '0;
        REQ_VALID = '0;
        REQ_LAST  = '0;
        REQ_MODE  = '1;
        REQ_DATA  = '0;

        // Reset values
        step(); step();
        #4;
        check("rst_gnt", GNT, 0);
        check("rst_rspv", RSP_VALID, 0);
        check("rst_rspd", RSP_DATA, 0);
        check("rst_busy", BUSY, 0);
        check("rst_detrst", DET_RST_B, 0);
        check("rst_divalid", DET_IN_VALID, 0);
        check("rst_dmode", DET_MODE, 3);
        check("rst_ddata", DET_DATA_IN, 0);
        step();
        RST_B = 1'b1;
        #4;
        check("rel_detrst_lo", DET_RST_B, 0);
        step();
        #4;
        check("rel_detrst_hi", DET_RST_B, 1);

        // Single requester INC burst
        step();
        REQ = 2'b01;
        #4;
        check("t1_idle_busy", BUSY, 0);
        step();
        #4;
        check("t1_flush_rst", DET_RST_B, 0);
        check("t1_flush_gnt", GNT, 0);
        check("t1_flush_busy", BUSY, 1);
        step();
        beat(0, 1, 0, MODE_INC, 1);
        #4;
        check("t1_gnt", GNT, 2'b01);
        check("t1_divalid", DET_IN_VALID, 1);
        check("t1_ddata", DET_DATA_IN, 1);
        check("t1_b1_rsp", RSP_VALID, 0);
        step();
        beat(0, 1, 0, MODE_INC, 2);
        #4;
        check("t1_b2_rsp", RSP_VALID, 0);
        step();
        beat(0, 1, 0, MODE_INC, 3);
        #4;
        check("t1_b3_rsp", RSP_VALID, 2'b01);
        check("t1_b3_data", RSP_DATA, 3);
        step();
        beat(0, 1, 1, MODE_INC, 4);
        #4;
        check("t1_b4_rsp", RSP_VALID, 2'b01);
        check("t1_b4_data", RSP_DATA, 4);
        check("t1_b4_mode", DET_MODE, MODE_INC);
        step();
        REQ = '0;
        quiet();
        #4;
        check("t1_end_gnt", GNT, 0);
        check("t1_end_busy", BUSY, 0);

        // Both requesting from reset: owners 0,1,0
        RST_B = 1'b0;
        step();
        RST_B = 1'b1;
        REQ   = 2'b11;
        #4;
        check("t2_idle_gnt", GNT, 0);
        step();
        #4;
        check("t2_f0_rst", DET_RST_B, 0);
        step();
        beat(0, 1, 0, MODE_INC, 1);
        beat(1, 1, 0, MODE_STEADY, 4);
        #4;
        check("t2_gnt0", GNT, 2'b01);
        check("t2_ignore_other", DET_DATA_IN, 1);
        step();
        beat(0, 1, 1, MODE_INC, 2);
        #4;
        check("t2_b2_rsp", RSP_VALID, 0);
        step();
        beat(0, 0, 0, MODE_HOLD, 0);
        #4;
        check("t2_gap_gnt", GNT, 0);
        check("t2_gap_rst", DET_RST_B, 1);
        step();
        #4;
        check("t2_f1_rst", DET_RST_B, 0);
        check("t2_f1_gnt", GNT, 0);
        step();
        #4;
        check("t2_gnt1", GNT, 2'b10);
        check("t2_s1_rsp", RSP_VALID, 0);
        step();
        #4;
        check("t2_s2_rsp", RSP_VALID, 0);
        step();
        beat(1, 1, 1, MODE_STEADY, 4);
        #4;
        check("t2_s3_rsp", RSP_VALID, 2'b10);
        check("t2_s3_data", RSP_DATA, 4);
        step();
        quiet();
        #4;
        check("t2_gap2_gnt", GNT, 0);
        step();
        #4;
        check("t2_f2_rst", DET_RST_B, 0);
        step();
        beat(0, 1, 1, MODE_INC, 7);
        #4;
        check("t2_gnt0_again", GNT, 2'b01);
        check("t2_flushed_rsp", RSP_VALID, 0);
        step();
        REQ = '0;
        quiet();
        #4;
        check("t2_end_gnt", GNT, 0);

        // Watchdog: 16 beats without LAST
        step();
        REQ = 2'b01;
        #4;
        step();
        #4;
        check("wd_flush_rst", DET_RST_B, 0);
        step();
        REQ = 2'b11;
        beat(0, 1, 0, MODE_STEADY, 5);
        beat(1, 0, 0, MODE_HOLD, 0);
        for (int k = 1; k <= 16; k++) begin
            #4;
            check("wd_gnt", GNT, 2'b01);
            if (k == 16) begin
                check("wd_b16_rsp", RSP_VALID, 2'b01);
                check("wd_b16_data", RSP_DATA, 5);
            end
            step();
        end
        #4;
        check("wd_end_gnt", GNT, 0);
        check("wd_end_busy", BUSY, 0);
        step();
        #4;
        check("wd_next_flush", DET_RST_B, 0);
        step();
        beat(1, 1, 1, MODE_INC, 9);
        #4;
        check("wd_next_gnt", GNT, 2'b10);
        step();
        REQ = '0;
        quiet();
        #4;
        check("wd_done_gnt", GNT, 0);

        // Owner drops REQ during FLUSH
        REQ = 2'b01;
        step();
        REQ = 2'b00;
        #4;
        check("ab_flush_rst", DET_RST_B, 0);
        check("ab_flush_gnt", GNT, 0);
        step();
        #4;
        check("ab_idle_gnt", GNT, 0);
        check("ab_idle_busy", BUSY, 0);
        REQ = 2'b11;
        step();
        #4;
        step();
        beat(0, 1, 0, MODE_INC, 1);
        #4;
        check("ab_same_owner", GNT, 2'b01);

        // HOLD beats count toward watchdog and keep detector history
        step();
        beat(0, 1, 0, MODE_INC, 2);
        #4;
        check("hd_b2_rsp", RSP_VALID, 0);
        for (int h = 3; h <= 15; h++) begin
            step();
            beat(0, 1, 0, MODE_HOLD, 9);
            #4;
            check("hd_rsp", RSP_VALID, 0);
            if (h == 3)
                check("hd_mode", DET_MODE, MODE_HOLD);
        end
        step();
        beat(0, 1, 0, MODE_INC, 3);
        #4;
        check("hd_b16_gnt", GNT, 2'b01);
        check("hd_b16_rsp", RSP_VALID, 2'b01);
        check("hd_b16_data", RSP_DATA, 3);
        step();
        REQ = '0;
        quiet();
        #4;
        check("hd_end_gnt", GNT, 0);

        // Reset mid-ACTIVE
        REQ = 2'b10;
        step();
        #4;
        step();
        beat(1, 1, 0, MODE_INC, 1);
        #4;
        check("mr_gnt", GNT, 2'b10);
        #2;
        RST_B = 1'b0;
        #1;
        check("mr_gnt_rst", GNT, 0);
        check("mr_busy_rst", BUSY, 0);
        check("mr_detrst", DET_RST_B, 0);
        check("mr_divalid", DET_IN_VALID, 0);
        check("mr_dmode", DET_MODE, 3);
        check("mr_rspv", RSP_VALID, 0);
        step();
        RST_B = 1'b1;
        REQ   = '0;
        quiet();
        #4;
        step();
        #4;
        check("mr_detrst_hi", DET_RST_B, 1);
        REQ = 2'b11;
        step();
        #4;
        step();
        #4;
        check("mr_first_owner", GNT, 2'b01);
        step();
        REQ = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_det_scheduler.md
# seq_det_scheduler

Shares one Sequence_Detector instance among N_REQ independent stream sources. A round-robin arbiter grants the detector to one requester for a whole burst and flushes the detector's history with a one-cycle local reset before each burst. The owner's beats are muxed into the detector, and OUT_VALID/DATA_OUT are steered back to that owner. The block sits between the stream sources and the detector, which stays unmodified.

## Interface
- N_REQ, 2: number of requesters (2..8).
- DW, 4: data width; matches detector DATA_IN.
- MAX_BURST, 16: maximum accepted beats per grant (watchdog).
- SYSCLK  in  1  system clock, rising edge.
- RST_B  in  1  reset, asynchronous, active-low.
- REQ  in  N_REQ  requester i wants the detector; held until granted and burst ends.
- REQ_VALID  in  N_REQ  beat valid, per requester.
- REQ_LAST  in  N_REQ  qualifies final beat of burst.
- REQ_MODE  in  2*N_REQ  packed mode, slice i = [2i+1:2i].
- REQ_DATA  in  DW*N_REQ  packed data, slice i.
- GNT  out  N_REQ  one-hot, owner may present beats.
- RSP_VALID  out  N_REQ  detector hit, routed to owner.
- RSP_DATA  out  DW  hit data (shared bus).
- BUSY  out  1  state != IDLE.
- DET_RST_B  out  1  registered local reset for the detector, ANDed with RST_B at the instance.
- DET_IN_VALID / DET_MODE / DET_DATA_IN  out  1/2/DW  detector inputs.
- DET_OUT_VALID / DET_DATA_OUT  in  1/DW  detector outputs (combinational, same cycle as input).

## Operation
- FSM states: IDLE=2'd0, FLUSH=2'd1, ACTIVE=2'd2. 2'd3 is unused and recovers to IDLE.
- IDLE: if any REQ, owner <= rr_pick(REQ, ptr) and go to FLUSH. Otherwise stay.
- FLUSH: DET_RST_B low for this cycle. Beat counter cleared. If REQ[owner] is still high, go to ACTIVE. Otherwise abort to IDLE with ptr unchanged.
- ACTIVE:
  - GNT[owner]=1.
  - DET_IN_VALID=REQ_VALID[owner], DET_MODE/DET_DATA_IN = owner slices.
  - Each cycle with REQ_VALID[owner] accepts one beat; the beat counter increments.
  - The burst ends on any of:
    - (a) REQ_VALID & REQ_LAST of owner;
    - (b) REQ[owner] low;
    - (c) accepted beat when counter == MAX_BURST-1.
  - The ending beat itself is still delivered to the detector. Simultaneous end conditions count as one end.
  - On end: go to IDLE and set ptr <= (owner+1) mod N_REQ.
- Outside ACTIVE, detector input is idle: DET_IN_VALID=0, DET_MODE=2'd3 (hold), DET_DATA_IN=0, GNT=0.
- RSP_VALID[owner]=DET_OUT_VALID only in ACTIVE, and RSP_DATA=DET_DATA_OUT. Otherwise all zero.
- Round-robin: search REQ starting at index ptr upward with wraparound; the first set bit wins. ptr reset value is 0.
- Non-owner beats are ignored. They are not dropped by the scheduler; sources hold them until granted.
- Beat counter width is clog2(MAX_BURST+1) and saturates at MAX_BURST, never wrapping.

## Timing
- Reset (RST_B low):
  - state=IDLE, ptr=0, owner=0, counter=0, DET_RST_B=0.
  - GNT, RSP_VALID, RSP_DATA, DET_IN_VALID, DET_DATA_IN = 0; DET_MODE=3; BUSY=0.
  - DET_RST_B rises at the first SYSCLK edge after RST_B release.
- DET_RST_B is registered: next = (next_state != FLUSH), so it is low exactly during FLUSH cycles.
- REQ first sampled high in IDLE at cycle t: FLUSH at t+1, GNT high and first beat accepted at t+2.
- Grant latency from idle is 2 cycles.
- Ending beat at cycle k: GNT low at k+1 (IDLE). The next owner's FLUSH is at k+2, so the minimum gap between bursts is 2 cycles.
- Response latency is 0 cycles (combinational pass-through of detector output).
- Reset mid-burst: immediate return to reset values. Owner and ptr are lost, and the detector is reset via DET_RST_B.

## Structure
- Package seq_det_pkg:
  - state encoding constants.
  - MODE constants INC=0, DEC=1, STEADY=2, HOLD=3.
  - default DW.
- Sub-module rr_pick: combinational, inputs REQ and ptr, outputs winner index and any-request flag.
- Owner mux, FSM, counter and ptr live in the top level.

## Test plan
- Single requester: REQ[0] rises at t, burst INC 1,2,3,4 with LAST on 4. Expect DET_RST_B low at t+1 and GNT=01 at t+2. RSP_VALID[0]=1 with RSP_DATA=3 and 4 on the 3rd and 4th beats; GNT=00 after the LAST beat.
- Both REQ high from reset: owners alternate 0,1,0. Each grant is preceded by exactly one DET_RST_B-low cycle. A stream of 4,4,4 on requester 1 right after requester 0's 1,2 yields no hit until its third 4.
- Watchdog, MAX_BURST=16: requester 0 sends 20 valid beats without LAST. Expect the grant to end after the 16th beat and requester 1 to be granted next if it is requesting.
- Owner drops REQ during FLUSH: return to IDLE, GNT never asserted, ptr unchanged, and the same requester wins on its next REQ.
- MODE=3 beats mid-burst are forwarded as hold and count toward the watchdog. The detector counter is unchanged and no spurious RSP_VALID is produced.
- RST_B pulsed low mid-ACTIVE: all outputs go to reset values immediately. After release, the first grant goes to requester 0.
